// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration onto hold_flag_o, deferred redirect sequencing,
// flush bubbles, debug halt and hold watchdog. Define PIPE_CTRL_PERF_EN for the stall counter.
module pipe_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_req_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              ex_hold_req_i,
    input  logic              bus_hold_req_i,
    input  logic              dbg_halt_req_i,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic [2:0]        hold_flag_o,
    output logic              flush_o,
    output logic              halted_o,
    output logic              timeout_o,
    output logic [31:0]       stall_cnt_o
);

    // state | meaning
    // RUN   | normal operation, redirects issue when not held
    // FLUSH | bubbles after a redirect, counter counts down to 1
    // HALT  | debug halt, pipe held at HOLD_ID
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_e;

    localparam logic [2:0]  HOLD_NONE = 3'd0;
    localparam logic [2:0]  HOLD_PC   = 3'd1;
    localparam logic [2:0]  HOLD_ID   = 3'd3;
    localparam logic [3:0]  FCNT_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WD_LIM    = 16'(HOLD_TIMEOUT);

    state_e              state_q, state_d;
    logic [3:0]          fcnt_q, fcnt_d;
    logic [15:0]         wd_q, wd_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                halted_q, halted_d;
    logic                hold_src;
    logic                dbg_hold;
    logic                held;
    logic                issue;

    // Combinational outputs are forced to their idle values while reset is asserted.
    always_comb begin
        hold_src = bus_hold_req_i || ex_hold_req_i;
        dbg_hold = (state_q == HALT) || (dbg_halt_req_i && (state_q == RUN));
        hold_flag_o = HOLD_NONE;
        if (rst) begin
            if (ex_hold_req_i || dbg_hold) begin
                hold_flag_o = HOLD_ID;
            end else if (bus_hold_req_i) begin
                hold_flag_o = HOLD_PC;
            end
        end
        held        = (hold_flag_o != HOLD_NONE);
        issue       = rst && !held && (state_q != HALT) && (jump_req_i || pend_q);
        jump_flag_o = issue;
        jump_addr_o = '0;
        if (issue) begin
            jump_addr_o = jump_req_i ? jump_addr_i : pend_addr_q;
        end
        flush_o   = issue || (rst && (state_q == FLUSH));
        timeout_o = rst && hold_src && (wd_q == WD_LIM - 16'd1);
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        wd_d        = '0;

        if (issue) begin
            pend_d = 1'b0;
        end else if (jump_req_i) begin
            pend_d      = 1'b1;
            pend_addr_d = jump_addr_i;
        end

        case (state_q)
            RUN: begin
                if (issue && (FLUSH_CYCLES > 1)) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_LOAD;
                end else if (dbg_halt_req_i) begin
                    state_d = HALT;
                end
            end
            FLUSH: begin
                if (issue) begin
                    fcnt_d = FCNT_LOAD;
                end else if (fcnt_q <= 4'd1) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            HALT: begin
                if (!dbg_halt_req_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // Saturate at the limit so the timeout pulses once per hold episode.
        if (hold_src) begin
            wd_d = (wd_q == WD_LIM) ? wd_q : wd_q + 16'd1;
        end
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            wd_q        <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            wd_q        <= wd_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            halted_q    <= halted_d;
        end
    end

    assign halted_o = halted_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q + {31'd0, held};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes model predictions, a negedge monitor
// pops and compares. Honours PIPE_CTRL_PERF_EN for the expected stall count.
module tb_pipe_ctrl;
    localparam int AW = 32;
    localparam int FC = 2;
    localparam int HT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          jump_req_i = 1'b0;
    logic [AW-1:0] jump_addr_i = '0;
    logic          ex_hold_req_i = 1'b0;
    logic          bus_hold_req_i = 1'b0;
    logic          dbg_halt_req_i = 1'b0;
    logic          jump_flag_o;
    logic [AW-1:0] jump_addr_o;
    logic [2:0]    hold_flag_o;
    logic          flush_o;
    logic          halted_o;
    logic          timeout_o;
    logic [31:0]   stall_cnt_o;

    pipe_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .rst(rst),
        .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
        .ex_hold_req_i(ex_hold_req_i), .bus_hold_req_i(bus_hold_req_i),
        .dbg_halt_req_i(dbg_halt_req_i),
        .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
        .hold_flag_o(hold_flag_o), .flush_o(flush_o), .halted_o(halted_o),
        .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        jf;
        logic [31:0] ja;
        logic [2:0]  hf;
        logic        fl;
        logic        ha;
        logic        to;
        logic [31:0] sc;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    // Reference model: abstract cycle-level view of the pipeline controller.
    bit          perf;
    bit          m_halt;
    int          m_flush_left;
    logic [31:0] m_pend[$];
    int          m_run;
    logic [31:0] m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("jump_flag", {31'd0, jump_flag_o}, {31'd0, e.jf});
            chk("jump_addr", jump_addr_o, e.ja);
            chk("hold_flag", {29'd0, hold_flag_o}, {29'd0, e.hf});
            chk("flush", {31'd0, flush_o}, {31'd0, e.fl});
            chk("halted", {31'd0, halted_o}, {31'd0, e.ha});
            chk("timeout", {31'd0, timeout_o}, {31'd0, e.to});
            chk("stall_cnt", stall_cnt_o, e.sc);
        end
    end

    task automatic model_reset();
        m_halt = 1'b0;
        m_flush_left = 0;
        m_pend.delete();
        m_run = 0;
        m_stall = '0;
    endtask

    task automatic step(input bit jr, input logic [31:0] ja, input bit ex, input bit bus, input bit dbg);
        exp_t e;
        bit in_flush, dbgh, held, issue;
        int lvl;
        @(posedge clk);
        #1;
        jump_req_i = jr;
        jump_addr_i = ja;
        ex_hold_req_i = ex;
        bus_hold_req_i = bus;
        dbg_halt_req_i = dbg;

        in_flush = (m_flush_left > 0);
        dbgh = m_halt || (dbg && !in_flush);
        lvl = (ex || dbgh) ? 3 : (bus ? 1 : 0);
        held = (lvl != 0);
        issue = !held && !m_halt && (jr || m_pend.size() > 0);
        m_run = (ex || bus) ? m_run + 1 : 0;

        e.jf = issue;
        e.ja = issue ? (jr ? ja : m_pend[0]) : 32'd0;
        e.hf = 3'(lvl);
        e.fl = issue || in_flush;
        e.ha = m_halt;
        e.to = (m_run == HT);
        e.sc = perf ? m_stall : 32'd0;
        sbq.push_back(e);

        if (held) m_stall = m_stall + 32'd1;
        if (issue) begin
            m_pend.delete();
        end else if (jr) begin
            m_pend.delete();
            m_pend.push_back(ja);
        end
        if (m_halt) m_halt = dbg;
        else if (!in_flush && !issue && dbg) m_halt = 1'b1;
        if (issue) m_flush_left = FC - 1;
        else if (in_flush) m_flush_left = m_flush_left - 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'd0, 0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d entries left want=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_jf"}, {31'd0, jump_flag_o}, 32'd0);
        chk({tag, "_ja"}, jump_addr_o, 32'd0);
        chk({tag, "_hf"}, {29'd0, hold_flag_o}, 32'd0);
        chk({tag, "_fl"}, {31'd0, flush_o}, 32'd0);
        chk({tag, "_ha"}, {31'd0, halted_o}, 32'd0);
        chk({tag, "_to"}, {31'd0, timeout_o}, 32'd0);
        chk({tag, "_sc"}, stall_cnt_o, 32'd0);
    endtask

    task automatic do_reset();
        drain();
        rst = 1'b0;
        jump_req_i = 1'b0;
        ex_hold_req_i = 1'b0;
        bus_hold_req_i = 1'b0;
        dbg_halt_req_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit ex_l, bus_l, dbg_l;
`ifdef PIPE_CTRL_PERF_EN
        perf = 1'b1;
`else
        perf = 1'b0;
`endif
        model_reset();
        // Reset with every request active: combinational outputs must still idle.
        jump_req_i = 1'b1;
        jump_addr_i = 32'hdead_beef;
        ex_hold_req_i = 1'b1;
        bus_hold_req_i = 1'b1;
        dbg_halt_req_i = 1'b1;
        #23;
        chk_reset_outputs("por");
        jump_req_i = 1'b0;
        ex_hold_req_i = 1'b0;
        bus_hold_req_i = 1'b0;
        dbg_halt_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        step(1, 32'h40, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 5; i++) step(i == 1, 32'h80, 1, 0, 0);
        idle(3);

        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        step(1, 32'h200, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 32'h100, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        idle(4);

        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        idle(1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        idle(2);

        do_reset();
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
        idle(1);
        step(1, 32'h300, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        drain();
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        model_reset();
        ex_hold_req_i = 1'b0;
        bus_hold_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(3);

        ex_l = 0;
        bus_l = 0;
        dbg_l = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) ex_l = !ex_l;
            if ($urandom_range(5) == 0) bus_l = !bus_l;
            if ($urandom_range(39) == 0) dbg_l = !dbg_l;
            step($urandom_range(3) == 0, $urandom, ex_l, bus_l, dbg_l);
        end
        idle(4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the RV32 core.
- Arbitrates stall requests from the execute stage, the bus and the debug halt, and drives the `hold_flag_i` bus of pc_reg and if_id from one source.
- Sequences branch/jump redirects to pc_reg: defers a redirect while the pipe is held, then flushes the younger stages for a fixed number of bubble cycles.
- Sits between ex/bus/debug and pc_reg, if_id and id_ex.

Parameters:
- ADDR_W, 32: width of jump address, equal to `MEM_ADDR_BUS` width.
- FLUSH_CYCLES, 2: total cycles `flush_o` is high per issued redirect, including the issue cycle. Legal range 1..15.
- HOLD_TIMEOUT, 255: consecutive held cycles before `timeout_o` pulses. Legal range 1..65535.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset (`RST` = 0)
- jump_req_i  in  1  redirect request from ex (one-cycle pulse)
- jump_addr_i  in  ADDR_W  redirect target, valid with `jump_req_i`
- ex_hold_req_i  in  1  level, multi-cycle ex op busy
- bus_hold_req_i  in  1  level, memory bus wait
- dbg_halt_req_i  in  1  level, debug halt request
- jump_flag_o  out  1  to pc_reg `jump_flag_i` (`JUMP_YES` = 1)
- jump_addr_o  out  ADDR_W  to pc_reg `jump_addr_i`
- hold_flag_o  out  `HOLD_FLAG_BUS`  to pc_reg/if_id; `HOLD_NONE`=0, `HOLD_PC`=1, `HOLD_IF`=2, `HOLD_ID`=3
- flush_o  out  1  insert NOP into if_id/id_ex
- halted_o  out  1  core halted (registered)
- timeout_o  out  1  one-cycle pulse, hold watchdog expired
- stall_cnt_o  out  32  held-cycle count (see optional feature)

Behaviour:
- States: RUN, FLUSH, HALT.
- Reset (`rst`=0, asynchronous): state RUN; pending jump cleared (`pend_q`=0, `pend_addr_q`=0); flush counter 0; watchdog 0; `halted_o`=0, `timeout_o`=0, `stall_cnt_o`=0.
- Combinational outputs during reset: `jump_flag_o`=0, `jump_addr_o`=0, `hold_flag_o`=`HOLD_NONE`, `flush_o`=0.
- hold_flag_o (combinational): maximum encoding of the active sources.
  - `bus_hold_req_i` -> `HOLD_PC`
  - `ex_hold_req_i` -> `HOLD_ID`
  - state HALT, or `dbg_halt_req_i` while in RUN -> `HOLD_ID`
  - otherwise `HOLD_NONE`
- held = (`hold_flag_o` != `HOLD_NONE`).
- can_issue = !held && state != HALT.
- issue (combinational) = can_issue && (`jump_req_i` || `pend_q`).
  - `jump_flag_o` = issue.
  - `jump_addr_o` = `jump_req_i` ? `jump_addr_i` : `pend_addr_q`; it is 0 when issue = 0.
  - A live request beats the pending one.
- Pending register:
  - Set when `jump_req_i`=1 and !can_issue; address captured. A later deferred request overwrites it.
  - Cleared on the cycle issue=1.
- `flush_o` = issue || state==FLUSH.
- RUN:
  - issue && FLUSH_CYCLES>1 -> FLUSH, counter loaded with FLUSH_CYCLES-1.
  - else `dbg_halt_req_i` -> HALT.
- FLUSH:
  - Counter decrements each cycle; at 1 -> RUN.
  - A new issue in FLUSH reloads the counter (the younger redirect wins).
  - `dbg_halt_req_i` is ignored until the flush completes, then RUN -> HALT on the next cycle.
  - A hold during FLUSH does not pause the counter.
- HALT:
  - `halted_o`=1 from the cycle after entry.
  - Exit to RUN the cycle after `dbg_halt_req_i` falls; `halted_o` clears with the state.
  - A pending jump issues on the first RUN cycle with no hold.
- Watchdog:
  - Counts consecutive cycles with `bus_hold_req_i` || `ex_hold_req_i`; cleared when both are low.
  - `timeout_o` pulses for one cycle when the count reaches HOLD_TIMEOUT, then the count saturates. No re-pulse until the hold releases.
  - Debug halt does not count.
- Reset mid-operation discards any pending jump and flush with no output glitch beyond reset values.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: `stall_cnt_o` increments every cycle held=1, wraps at 2^32, and is cleared only by reset.
- Undefined: `stall_cnt_o` is tied to 0 and no counter flops are generated. The port is present either way.

Test Plan:
- Reset, then `jump_req_i`=1, `jump_addr_i`=0x40 in RUN with no holds -> same cycle `jump_flag_o`=1, `jump_addr_o`=0x40, `flush_o`=1; next cycle `flush_o`=1; third cycle `flush_o`=0, state RUN.
- `ex_hold_req_i` high 5 cycles, `jump_req_i` pulse 0x80 on cycle 2 -> `hold_flag_o`=`HOLD_ID` for 5 cycles and `jump_flag_o`=0 throughout; on the first cycle after hold drops, `jump_flag_o`=1, `jump_addr_o`=0x80.
- `bus_hold_req_i` and `ex_hold_req_i` together -> `HOLD_ID`; bus alone -> `HOLD_PC`; neither -> `HOLD_NONE`.
- `dbg_halt_req_i` raised during FLUSH -> halt entered only after the flush ends, `halted_o`=1 one cycle later; pending jump 0x100 issued on the first RUN cycle after the request drops.
- HOLD_TIMEOUT=4, bus hold held 10 cycles -> exactly one `timeout_o` pulse on the 4th held cycle; release and re-hold 4 cycles -> second pulse.
- With PIPE_CTRL_PERF_EN, 7 held cycles -> `stall_cnt_o`=7. Assert `rst`=0 mid-hold -> all outputs at reset values asynchronously.
